// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers for the multicycle MIPS datapath.
// Optional macro MDU_FAST_MUL_EN: single-cycle multiplier for mult/multu; divides stay iterative.
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state, state_nx;
    logic        is_div, qneg, rneg, bz;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opb;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_nx, div_nx, mul_fix;
    logic [33:0] div_diff;
    logic [31:0] quo_fix, rem_fix;

    // op[0]=1 selects the unsigned variants
    assign a_neg = ~op[0] & a[31];
    assign b_neg = ~op[0] & b[31];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    assign mul_nx  = {mul_sum, acc[31:1]};

    // Divide: acc = {remainder, dividend bits shifting into quotient}
    assign div_diff = {1'b0, acc[63:31]} - {2'b00, opb};
    assign div_nx   = div_diff[33] ? {acc[62:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};

    assign mul_fix = qneg ? -acc : acc;
    assign quo_fix = qneg ? -acc[31:0] : acc[31:0];
    assign rem_fix = rneg ? -acc[63:32] : acc[63:32];

`ifdef MDU_FAST_MUL_EN
    logic [63:0] ext_a, ext_b, fast_prod;
    assign ext_a     = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
    assign ext_b     = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
    assign fast_prod = ext_a * ext_b;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MDU_FAST_MUL_EN
                    state_nx = op[1] ? RUN : FINISH;
`else
                    state_nx = RUN;
`endif
                end
            end
            RUN:     if (cnt == 5'd31) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            bz     <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
        end else begin
            done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (hi_wr) hi <= wdata;
                    if (lo_wr) lo <= wdata;
                    if (start) begin
                        is_div <= op[1];
                        qneg   <= a_neg ^ b_neg;
                        rneg   <= a_neg;
                        bz     <= (b == 32'd0);
                        cnt    <= '0;
                        acc    <= {32'd0, a_mag};
                        opb    <= b_mag;
`ifdef MDU_FAST_MUL_EN
                        if (!op[1]) begin
                            acc  <= fast_prod;
                            qneg <= 1'b0;
                        end
`endif
                    end
                end
                RUN: begin
                    acc <= is_div ? div_nx : mul_nx;
                    cnt <= cnt + 5'd1;
                end
                FINISH: begin
                    // Unsigned restoring divide by zero already yields rem=|a|; only lo needs forcing
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= bz ? 32'hFFFF_FFFF : quo_fix;
                    end else begin
                        {hi, lo} <= mul_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: random and directed ops checked against an arithmetic reference model.
module tb_mdu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0, b = '0;
    logic        hi_wr = 1'b0, lo_wr = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mdu dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
             .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
             .busy(busy), .done(done), .hi(hi), .lo(lo));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        prev_busy = 1'b0;
    logic [31:0] prev_hi = '0, prev_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endfunction

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] ux, uy;
        int          q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'd0: return 64'(sx * sy);
            2'd1: return ux * uy;
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic int latency(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
        return o[1] ? 33 : 1;
`else
        return (o == 2'd0 || o != 2'd0) ? 33 : 33;
`endif
    endfunction

    // Monitor: pops the scoreboard on every done pulse; HI/LO must hold while busy
    always @(negedge clk) begin
        if (!reset) begin
            prev_busy = 1'b0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", {hi, lo}, {e.hi, e.lo});
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (busy && prev_busy)
                check("hold_while_busy", {hi, lo}, {prev_hi, prev_lo});
            prev_busy = busy;
            prev_hi   = hi;
            prev_lo   = lo;
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.hi  = exp[63:32];
        e.lo  = exp[31:0];
        e.cyc = cyc + latency(o);
        sb.push_back(e);
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        // mtlo in idle
        lo_wr = 1'b1;
        wdata = 32'hABCD;
        @(posedge clk);
        #1;
        lo_wr = 1'b0;
        check("mtlo", {32'd0, lo}, 64'h0000_ABCD);

        @(negedge clk);
        issue(2'd0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        wait_done();
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        wait_done();
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_done();
        issue(2'd3, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
        wait_done();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        wait_done();
        issue(2'd2, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        wait_done();
        issue(2'd2, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);
        wait_done();

        // start and mthi while busy are both ignored
        issue(2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd5;
        hi_wr = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        hi_wr = 1'b0;
        wait_done();

        // mthi in the same cycle as start: write lands, operation still runs
        hi_wr = 1'b1;
        wdata = 32'h5555;
        issue(2'd1, 32'd6, 32'd7, 64'h0000_0000_0000_002A);
        hi_wr = 1'b0;
        check("mthi_with_start", {32'd0, hi}, 64'h0000_5555);
        wait_done();

        // reset mid-divide aborts with no done pulse
        @(negedge clk);
        hi_wr = 1'b1;
        wdata = 32'hDEAD;
        @(negedge clk);
        hi_wr = 1'b0;
        start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_idle", {63'd0, busy}, 64'd0);

        // randomized, back-to-back whenever no gap is chosen
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(ro, ra, rb, model(ro, ra, rb));
            wait_done();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
